vending_ctrl_param: RTL and testbench

- Parametrised successor to the single-product coin FSM: multi-product vending controller with configurable price, credit ceiling, product count and per-product stock.
- Accepts coins (1/2/5 units) and a product selection; dispenses on sufficient credit.
- Returns change or refunds as a coin-by-coin stream over a valid/ready handshake to the coin hopper.
- Sits between the coin/keypad front end and the dispenser/hopper drivers.

---
 rtl/vending_ctrl_param.sv | 217 +++++++++++++++++++++
 tb/tb_vending_ctrl_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl_param.sv
// Multi-product vending controller: coin credit, product selection with stock tracking,
// and greedy coin-by-coin change/refund over a valid/ready hopper handshake.
module vending_ctrl_param #(
   parameter int PRICE      = 7,
   parameter int MAX_CREDIT = 15,
   parameter int CREDIT_W   = 4,
   parameter int NUM_PROD   = 4,
   parameter int STOCK_W    = 3,
   parameter int STOCK_INIT = 2,
   localparam int SEL_W     = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [2:0]          coin,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel,
   input  logic                cancel,
   input  logic                restock,
   input  logic                change_ready,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic                coin_reject,
   output logic                sel_err,
   output logic                dispense_valid,
   output logic [SEL_W-1:0]    dispense_id,
   output logic                change_valid,
   output logic [2:0]          change_coin,
   output logic [NUM_PROD-1:0] stock_empty
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VEND    = 2'd2,
      ST_CHANGE  = 2'd3
   } state_t;

   localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_C        = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [STOCK_W-1:0]  STOCK_INIT_C = STOCK_W'(STOCK_INIT);
   localparam logic [SEL_W:0]      NUM_PROD_C   = (SEL_W+1)'(NUM_PROD);
   localparam logic [CREDIT_W+2:0] FIVE_C       = (CREDIT_W+3)'(5);
   localparam logic [CREDIT_W+2:0] TWO_C        = (CREDIT_W+3)'(2);

   state_t                state_r;
   logic [CREDIT_W-1:0]   credit_r;
   logic [CREDIT_W-1:0]   rem_r;
   logic [STOCK_W-1:0]    stock_r [NUM_PROD];
   logic                  busy_r;
   logic                  coin_reject_r;
   logic                  sel_err_r;
   logic                  dispense_valid_r;
   logic [SEL_W-1:0]      dispense_id_r;
   logic                  change_valid_r;
   logic [2:0]            change_coin_r;
   logic [NUM_PROD-1:0]   stock_empty_r;

   logic [CREDIT_W:0]     sum_s;
   logic                  coin_ok_s;
   logic [STOCK_W-1:0]    stock_sel_s;
   logic                  sel_ok_s;
   logic                  accepting_s;
   logic                  vend_go_s;
   logic [CREDIT_W-1:0]   rem_next_s;
   logic [STOCK_W-1:0]    stock_next_s [NUM_PROD];
   logic [NUM_PROD-1:0]   empty_next_s;

   // Largest hopper coin not exceeding the amount still owed.
   function automatic logic [2:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
      logic [CREDIT_W+2:0] a;
      a = {3'b000, amt};
      if (a >= FIVE_C) begin
         greedy_coin = 3'd5;
      end else if (a >= TWO_C) begin
         greedy_coin = 3'd2;
      end else if (a != {(CREDIT_W+3){1'b0}}) begin
         greedy_coin = 3'd1;
      end else begin
         greedy_coin = 3'd0;
      end
   endfunction

   assign credit         = credit_r;
   assign busy           = busy_r;
   assign coin_reject    = coin_reject_r;
   assign sel_err        = sel_err_r;
   assign dispense_valid = dispense_valid_r;
   assign dispense_id    = dispense_id_r;
   assign change_valid   = change_valid_r;
   assign change_coin    = change_coin_r;
   assign stock_empty    = stock_empty_r;

   // Coin acceptance and selection qualification for the current cycle.
   always_comb begin
      accepting_s = (state_r == ST_IDLE) || (state_r == ST_COLLECT);
      sum_s       = {1'b0, credit_r} + (CREDIT_W+1)'(coin);
      coin_ok_s   = ((coin == 3'd1) || (coin == 3'd2) || (coin == 3'd5)) && (sum_s <= MAX_C);
      stock_sel_s = {STOCK_W{1'b0}};
      for (int i = 0; i < NUM_PROD; i++) begin
         stock_sel_s = (sel == SEL_W'(i)) ? stock_r[i] : stock_sel_s;
      end
      sel_ok_s   = ({1'b0, sel} < NUM_PROD_C) && (stock_sel_s != {STOCK_W{1'b0}}) &&
                   (credit_r >= PRICE_C);
      vend_go_s  = accepting_s && !cancel && sel_valid && sel_ok_s;
      rem_next_s = rem_r - CREDIT_W'(change_coin_r);
   end

   // Next stock levels; a restock overrides a coincident vend decrement.
   always_comb begin
      for (int i = 0; i < NUM_PROD; i++) begin
         if (restock) begin
            stock_next_s[i] = STOCK_INIT_C;
         end else if (vend_go_s && (sel == SEL_W'(i))) begin
            stock_next_s[i] = stock_r[i] - STOCK_W'(1);
         end else begin
            stock_next_s[i] = stock_r[i];
         end
         empty_next_s[i] = (stock_next_s[i] == {STOCK_W{1'b0}});
      end
   end

   // Controller FSM with registered outputs and stock counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= ST_IDLE;
         credit_r         <= {CREDIT_W{1'b0}};
         rem_r            <= {CREDIT_W{1'b0}};
         busy_r           <= 1'b0;
         coin_reject_r    <= 1'b0;
         sel_err_r        <= 1'b0;
         dispense_valid_r <= 1'b0;
         dispense_id_r    <= {SEL_W{1'b0}};
         change_valid_r   <= 1'b0;
         change_coin_r    <= 3'd0;
         for (int i = 0; i < NUM_PROD; i++) begin
            stock_r[i]       <= STOCK_INIT_C;
            stock_empty_r[i] <= (STOCK_INIT_C == {STOCK_W{1'b0}});
         end
      end else begin
         coin_reject_r    <= 1'b0;
         sel_err_r        <= 1'b0;
         dispense_valid_r <= 1'b0;
         stock_r          <= stock_next_s;
         stock_empty_r    <= empty_next_s;
         case (state_r)
            ST_IDLE, ST_COLLECT: begin
               // Only the highest-priority event acts; a coin losing arbitration is rejected.
               if (cancel) begin
                  coin_reject_r <= coin_valid;
                  if (state_r == ST_COLLECT) begin
                     rem_r          <= credit_r;
                     credit_r       <= {CREDIT_W{1'b0}};
                     state_r        <= ST_CHANGE;
                     busy_r         <= 1'b1;
                     change_valid_r <= 1'b1;
                     change_coin_r  <= greedy_coin(credit_r);
                  end
               end else if (sel_valid) begin
                  coin_reject_r <= coin_valid;
                  if (sel_ok_s) begin
                     state_r          <= ST_VEND;
                     busy_r           <= 1'b1;
                     dispense_valid_r <= 1'b1;
                     dispense_id_r    <= sel;
                     rem_r            <= credit_r - PRICE_C;
                     credit_r         <= {CREDIT_W{1'b0}};
                  end else begin
                     sel_err_r <= 1'b1;
                  end
               end else if (coin_valid) begin
                  if (coin_ok_s) begin
                     credit_r <= sum_s[CREDIT_W-1:0];
                     state_r  <= ST_COLLECT;
                  end else begin
                     coin_reject_r <= 1'b1;
                  end
               end
            end
            ST_VEND: begin
               coin_reject_r <= coin_valid;
               sel_err_r     <= sel_valid;
               if (rem_r != {CREDIT_W{1'b0}}) begin
                  state_r        <= ST_CHANGE;
                  change_valid_r <= 1'b1;
                  change_coin_r  <= greedy_coin(rem_r);
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_CHANGE: begin
               coin_reject_r <= coin_valid;
               sel_err_r     <= sel_valid;
               if (change_valid_r && change_ready) begin
                  rem_r <= rem_next_s;
                  if (rem_next_s == {CREDIT_W{1'b0}}) begin
                     state_r        <= ST_IDLE;
                     busy_r         <= 1'b0;
                     change_valid_r <= 1'b0;
                     change_coin_r  <= 3'd0;
                  end else begin
                     change_coin_r <= greedy_coin(rem_next_s);
                  end
               end
            end
            default: begin
               state_r        <= ST_IDLE;
               busy_r         <= 1'b0;
               change_valid_r <= 1'b0;
               change_coin_r  <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Scoreboard bench for vending_ctrl_param: stimulus queues expected dispense/change/
// reject/refusal events, a negedge monitor pops and compares them as the DUT emits them.
module tb_vending_ctrl_param;

   localparam int SEL_W    = 2;
   localparam int CREDIT_W = 4;
   localparam int NUM_PROD = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                coin_valid = 1'b0;
   logic [2:0]          coin = 3'd0;
   logic                sel_valid = 1'b0;
   logic [SEL_W-1:0]    sel = 2'd0;
   logic                cancel = 1'b0;
   logic                restock = 1'b0;
   logic                change_ready = 1'b0;
   logic [CREDIT_W-1:0] credit;
   logic                busy;
   logic                coin_reject;
   logic                sel_err;
   logic                dispense_valid;
   logic [SEL_W-1:0]    dispense_id;
   logic                change_valid;
   logic [2:0]          change_coin;
   logic [NUM_PROD-1:0] stock_empty;

   int tests = 0;
   int fails = 0;
   int exp_disp[$];
   int exp_chg[$];
   int exp_rej[$];
   int exp_serr[$];
   int mon_e;

   vending_ctrl_param dut (
      .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
      .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .restock(restock),
      .change_ready(change_ready), .credit(credit), .busy(busy),
      .coin_reject(coin_reject), .sel_err(sel_err), .dispense_valid(dispense_valid),
      .dispense_id(dispense_id), .change_valid(change_valid), .change_coin(change_coin),
      .stock_empty(stock_empty)
   );

   always #5 clk = ~clk;

   // Monitor: every output event must match the head of its expectation queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (dispense_valid === 1'b1) begin
            tests++;
            if (exp_disp.size() == 0) begin
               fails++;
               $display("FAIL dispense: got unexpected id %0d, expected none", dispense_id);
            end else begin
               mon_e = exp_disp.pop_front();
               if (int'(dispense_id) != mon_e) begin
                  fails++;
                  $display("FAIL dispense_id: got %0d, expected %0d", dispense_id, mon_e);
               end
            end
         end
         if (change_valid === 1'b1 && change_ready === 1'b1) begin
            tests++;
            if (exp_chg.size() == 0) begin
               fails++;
               $display("FAIL change: got unexpected coin %0d, expected none", change_coin);
            end else begin
               mon_e = exp_chg.pop_front();
               if (int'(change_coin) != mon_e) begin
                  fails++;
                  $display("FAIL change_coin: got %0d, expected %0d", change_coin, mon_e);
               end
            end
         end
         if (coin_reject === 1'b1) begin
            tests++;
            if (exp_rej.size() == 0) begin
               fails++;
               $display("FAIL coin_reject: got unexpected pulse, expected none");
            end else begin
               mon_e = exp_rej.pop_front();
            end
         end
         if (sel_err === 1'b1) begin
            tests++;
            if (exp_serr.size() == 0) begin
               fails++;
               $display("FAIL sel_err: got unexpected pulse, expected none");
            end else begin
               mon_e = exp_serr.pop_front();
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic cv, input logic [2:0] cval, input logic sv,
                        input logic [SEL_W-1:0] s, input logic can, input logic rs);
      coin_valid = cv; coin = cval; sel_valid = sv; sel = s; cancel = can; restock = rs;
      cyc();
      coin_valid = 1'b0; coin = 3'd0; sel_valid = 1'b0; sel = 2'd0;
      cancel = 1'b0; restock = 1'b0;
   endtask

   task automatic coin_in(input logic [2:0] v);
      drive(1'b1, v, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic sel_in(input logic [SEL_W-1:0] s);
      drive(1'b0, 3'd0, 1'b1, s, 1'b0, 1'b0);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 40 && (busy || change_valid); i++) cyc();
      chk(name, int'(busy || change_valid), 0);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      cyc();
      chk("rst_credit", int'(credit), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_change_valid", int'(change_valid), 0);
      chk("rst_change_coin", int'(change_coin), 0);
      chk("rst_stock_empty", int'(stock_empty), 0);
      rst = 1'b0;
      cyc();

      // Cancel in IDLE does nothing
      drive(1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("idle_cancel_busy", int'(busy), 0);

      // Exact payment
      coin_in(3'd5); chk("exact_credit5", int'(credit), 5);
      coin_in(3'd2); chk("exact_credit7", int'(credit), 7);
      exp_disp.push_back(1);
      sel_in(2'd1);
      chk("exact_vend_credit", int'(credit), 0);
      chk("exact_vend_busy", int'(busy), 1);
      cyc();
      chk("exact_idle_busy", int'(busy), 0);
      chk("exact_no_change", int'(change_valid), 0);

      // Change with backpressure; a coin during CHANGE is rejected
      change_ready = 1'b0;
      coin_in(3'd5); coin_in(3'd5);
      chk("bp_credit10", int'(credit), 10);
      exp_disp.push_back(0);
      sel_in(2'd0);
      cyc();
      chk("bp_valid", int'(change_valid), 1);
      chk("bp_coin0", int'(change_coin), 2);
      exp_rej.push_back(1);
      coin_in(3'd1);
      chk("bp_coin1", int'(change_coin), 2);
      cyc(); chk("bp_coin2", int'(change_coin), 2);
      cyc(); chk("bp_coin3", int'(change_coin), 2);
      chk("bp_valid_hold", int'(change_valid), 1);
      exp_chg.push_back(2); exp_chg.push_back(1);
      change_ready = 1'b1;
      cyc(); chk("bp_second_coin", int'(change_coin), 1);
      cyc();
      chk("bp_done_valid", int'(change_valid), 0);
      chk("bp_done_busy", int'(busy), 0);

      // Overflow and illegal coins, then full refund
      coin_in(3'd5); coin_in(3'd5); coin_in(3'd5);
      chk("ovf_credit15", int'(credit), 15);
      exp_rej.push_back(1);
      coin_in(3'd1); chk("ovf_credit_hold", int'(credit), 15);
      exp_rej.push_back(1);
      coin_in(3'd3); chk("illegal_credit_hold", int'(credit), 15);
      exp_chg.push_back(5); exp_chg.push_back(5); exp_chg.push_back(5);
      drive(1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("cancel_credit", int'(credit), 0);
      wait_idle("cancel_refund_idle");

      // Refusals and priority
      coin_in(3'd5);
      exp_serr.push_back(1);
      sel_in(2'd2); chk("low_credit_sel", int'(credit), 5);
      exp_serr.push_back(1); exp_rej.push_back(1);
      drive(1'b1, 3'd1, 1'b1, 2'd2, 1'b0, 1'b0);
      chk("sel_coin_credit", int'(credit), 5);
      exp_chg.push_back(5);
      drive(1'b0, 3'd0, 1'b1, 2'd0, 1'b1, 1'b0);
      chk("cancel_sel_credit", int'(credit), 0);
      wait_idle("cancel_sel_idle");

      // Stock exhaustion and restock
      for (int k = 0; k < 2; k++) begin
         coin_in(3'd5); coin_in(3'd2);
         exp_disp.push_back(3);
         sel_in(2'd3);
         wait_idle("stock_vend_idle");
      end
      chk("stock_empty3", int'(stock_empty), 8);
      coin_in(3'd5); coin_in(3'd2);
      exp_serr.push_back(1);
      sel_in(2'd3); chk("empty_sel_credit", int'(credit), 7);
      drive(1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1);
      chk("restock_empty", int'(stock_empty), 0);
      exp_disp.push_back(3);
      sel_in(2'd3);
      chk("restock_vend_busy", int'(busy), 1);
      wait_idle("restock_vend_idle");

      // Reset during CHANGE
      change_ready = 1'b0;
      coin_in(3'd5); coin_in(3'd5);
      exp_disp.push_back(0);
      sel_in(2'd0);
      cyc();
      chk("midrst_pre_valid", int'(change_valid), 1);
      rst = 1'b1;
      cyc();
      chk("midrst_valid", int'(change_valid), 0);
      chk("midrst_credit", int'(credit), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_stock", int'(stock_empty), 0);
      rst = 1'b0;
      cyc(); cyc();
      chk("post_rst_valid", int'(change_valid), 0);

      // Drain: nothing expected may remain outstanding
      cyc();
      chk("left_disp", exp_disp.size(), 0);
      chk("left_chg", exp_chg.size(), 0);
      chk("left_rej", exp_rej.size(), 0);
      chk("left_serr", exp_serr.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
